mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum grant length in cycles; used only when the timeout feature is compiled in; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 resetn  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 req  input  4  request lines; req[i] high = requester i wants the shared 4:1 mux path.
REQ-005 done  input  4  release strobes; done[i] high for one or more cycles = requester i has finished.
REQ-006 sel  output  2  registered select for the 4:1 mux: sel[0] to the first-level select, sel[1] to the second-level select; sel = granted index.
REQ-007 grant  output  4  registered one-hot grant; all-zero when no grant is held.
REQ-008 busy  output  1  high while in GRANT or RELEASE.
REQ-009 timeout  output  1  one-cycle pulse on a forced release (feature-dependent; see Configuration).

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, GRANT and RELEASE.
REQ-011 The FSM SHALL move IDLE -> GRANT on the edge where req != 0, with grant and sel valid from that edge, giving a 1-cycle request-to-grant latency.
REQ-012 Arbitration SHALL be round-robin from 2-bit pointer ptr, searching (ptr+1), (ptr+2), (ptr+3), ptr mod 4, taking the first set req bit, and loading ptr with the winner on entry to GRANT.
REQ-013 In GRANT, grant and sel SHALL remain constant, with no preemption by other requesters.
REQ-014 The FSM SHALL move GRANT -> RELEASE on the edge where done[g] == 1 or req[g] == 0, where g is the granted index.
REQ-015 done[i] for i != g SHALL be ignored.
REQ-016 In RELEASE, grant SHALL be 0 and sel SHALL hold its last value for exactly one cycle (dead cycle on the mux path).
REQ-017 The FSM SHALL move RELEASE -> GRANT on the next edge, re-arbitrating per REQ-012, if req != 0; otherwise it SHALL move to IDLE.
REQ-018 A new grant SHALL be issued no earlier than 2 cycles after the done edge.
REQ-019 A requester that is still requesting after release SHALL be served again only after every other active requester has been served once.
REQ-020 When all four requesters are continuously active, grants SHALL be issued in the order 0,1,2,3,0,... after reset.
REQ-021 busy SHALL equal (state != IDLE).
REQ-022 sel SHALL hold its value in IDLE.

Reset
REQ-023 While resetn == 0 at an edge, the block SHALL set state = IDLE, grant = 4'b0000, sel = 2'b00, busy = 0, timeout = 0, ptr = 2'b11 and the hold counter to 0.
REQ-024 Reset asserted mid-grant SHALL abort the grant at that edge with no RELEASE cycle and no timeout pulse.
REQ-025 The first grant after reset SHALL go to the lowest-numbered active requester.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN, when defined, SHALL add an 8-bit hold counter that is cleared on entry to GRANT and incremented each GRANT cycle.
REQ-027 With ARB_TIMEOUT_EN defined, if the counter reaches MAX_HOLD-1 without a release condition, the FSM SHALL enter RELEASE on the next edge, assert timeout for that RELEASE cycle only, and advance ptr so the timed-out requester gets lowest priority.
REQ-028 With ARB_TIMEOUT_EN defined, a release condition and a timeout in the same cycle SHALL be treated as a normal release with timeout = 0.
REQ-029 Without ARB_TIMEOUT_EN, the counter SHALL be absent, timeout SHALL be tied to 0, MAX_HOLD SHALL be ignored, and a grant SHALL be held until its release condition.

Verification
REQ-030 Reset, then req=4'b0100 -> grant=4'b0100 and sel=2'b10 one edge later; done[2] pulse -> grant=0 next edge, busy=0 the edge after.
REQ-031 req=4'b1111 held, with done[g] pulsed one cycle after each grant -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-032 Grant to 1 with done[3] pulsed -> grant stays 4'b0010; then req[1] dropped -> RELEASE next edge.
REQ-033 resetn=0 driven mid-grant on requester 3 -> next edge grant=0, sel=0, busy=0, timeout=0; after release with req=4'b1010 -> grant=4'b0010.
REQ-034 ARB_TIMEOUT_EN defined, MAX_HOLD=4, req=4'b0011 with no done -> requester 0 held 4 cycles, then timeout=1 for one cycle with grant=0, then grant=4'b0010.
REQ-035 ARB_TIMEOUT_EN undefined, req=4'b0001 held for 300 cycles -> grant stays 4'b0001 and timeout stays 0 throughout.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux path. The grant is held until the owner releases it, and each release is followed by one dead cycle.
// Define ARB_TIMEOUT_EN to add a hold counter that forces a release after MAX_HOLD cycles and pulses timeout.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] winner;
    logic       found;
    logic       anyReq;
    logic       relCond;
    logic       holdExpired;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : gBadMaxHold
        $error("mux4_rr_arbiter: MAX_HOLD must be within 2..255");
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);
    logic [7:0] holdCnt_q, holdCnt_d;
    logic       timeout_q, timeout_d;
    assign holdExpired = (holdCnt_q == HoldLast);
`else
    assign holdExpired = 1'b0;
`endif

    assign anyReq  = |req;
    assign relCond = done[sel_q] | ~req[sel_q];

    // The search starts just after the last winner, so the last winner has the lowest priority.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!found && req[ptr_q + 2'(i)]) begin
                winner = ptr_q + 2'(i);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            ptr_q     <= 2'b11;
            sel_q     <= 2'b00;
            grant_q   <= 4'b0000;
`ifdef ARB_TIMEOUT_EN
            holdCnt_q <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
`ifdef ARB_TIMEOUT_EN
            holdCnt_q <= holdCnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        grant_d   = 4'b0000;
`ifdef ARB_TIMEOUT_EN
        holdCnt_d = holdCnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE, RELEASE: begin
                if (anyReq) begin
                    state_d   = GRANT;
                    ptr_d     = winner;
                    sel_d     = winner;
                    grant_d   = 4'b0001 << winner;
`ifdef ARB_TIMEOUT_EN
                    holdCnt_d = 8'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // A real release wins over an expiring hold counter, so timeout stays low.
                if (relCond) begin
                    state_d = RELEASE;
                end else if (holdExpired) begin
                    state_d   = RELEASE;
`ifdef ARB_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end else begin
                    grant_d   = grant_q;
`ifdef ARB_TIMEOUT_EN
                    holdCnt_d = holdCnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy  = (state_q != IDLE);
        grant = grant_q;
        sel   = sel_q;
`ifdef ARB_TIMEOUT_EN
        timeout = timeout_q;
`else
        timeout = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter: directed scenarios plus random traffic, checked against a cycle-level behavioural model of the arbiter.
module tb_mux4_rr_arbiter;

   localparam int TbMaxHold = 4;

   logic       clk;
   logic       resetn;
   logic [3:0] req;
   logic [3:0] done;
   logic [1:0] sel;
   logic [3:0] grant;
   logic       busy;
   logic       timeout;

   int checks;
   int errors;

   // Model state: phase 0 = idle, 1 = owner holds the path, 2 = dead cycle.
   int         mPhase;
   int         mOwner;
   int         mLast;
   int         mHeldCycles;
   logic [1:0] mSel;
   logic       mTimeout;
   logic [3:0] mGrant;

   mux4_rr_arbiter #(.MAX_HOLD(TbMaxHold)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .req     (req),
      .done    (done),
      .sel     (sel),
      .grant   (grant),
      .busy    (busy),
      .timeout (timeout)
   );

   // Free-running clock with a 10-time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value with the bench's expected value and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Advances the model across one rising edge, using the inputs sampled at that edge.
   task automatic modelStep(input logic rn, input logic [3:0] r, input logic [3:0] d);
      int cand;
      bit picked;
      if (!rn) begin
         mPhase = 0;
         mLast = 3;
         mSel = 2'b00;
         mTimeout = 1'b0;
         mHeldCycles = 0;
      end else if (mPhase == 1) begin
         mTimeout = 1'b0;
         if (d[mOwner] || !r[mOwner]) begin
            mPhase = 2;
         end else begin
`ifdef ARB_TIMEOUT_EN
            if (mHeldCycles == TbMaxHold) begin
               mPhase = 2;
               mTimeout = 1'b1;
            end else begin
               mHeldCycles++;
            end
`else
            mHeldCycles++;
`endif
         end
      end else begin
         mTimeout = 1'b0;
         picked = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            cand = (mLast + k) % 4;
            if (!picked && r[cand]) begin
               picked = 1'b1;
               mOwner = cand;
            end
         end
         if (picked) begin
            mPhase = 1;
            mLast = mOwner;
            mSel = 2'(mOwner);
            mHeldCycles = 1;
         end else begin
            mPhase = 0;
         end
      end
      mGrant = (mPhase == 1) ? 4'(1 << mOwner) : 4'b0000;
   endtask

   // Drives one cycle of inputs, then checks every output against the model.
   task automatic applyStimulus(input logic rn, input logic [3:0] r, input logic [3:0] d);
      @(negedge clk);
      resetn = rn;
      req = r;
      done = d;
      modelStep(rn, r, d);
      @(posedge clk);
      #1;
      checkOutput("grant", 8'(grant), 8'(mGrant));
      checkOutput("sel", 8'(sel), 8'(mSel));
      checkOutput("busy", 8'(busy), 8'(mPhase != 0));
      checkOutput("timeout", 8'(timeout), 8'(mTimeout));
   endtask

   initial begin
      logic [3:0] expSeq [9];
      logic [3:0] rr;
      logic [3:0] dd;
      logic       rn;
      checks = 0;
      errors = 0;
      resetn = 1'b0;
      req = 4'b0000;
      done = 4'b0000;
      mPhase = 0;
      mOwner = 0;
      mLast = 3;
      mHeldCycles = 0;
      mSel = 2'b00;
      mTimeout = 1'b0;
      mGrant = 4'b0000;

      // Reset state, then a single requester with done.
      applyStimulus(1'b0, 4'b0000, 4'b0000);
      applyStimulus(1'b0, 4'b0000, 4'b0000);
      checkOutput("reset_grant", 8'(grant), 8'h00);
      checkOutput("reset_busy", 8'(busy), 8'h00);
      applyStimulus(1'b1, 4'b0100, 4'b0000);
      checkOutput("single_grant", 8'(grant), 8'h04);
      checkOutput("single_sel", 8'(sel), 8'h02);
      applyStimulus(1'b1, 4'b0000, 4'b0100);
      checkOutput("single_release", 8'(grant), 8'h00);
      checkOutput("single_dead_busy", 8'(busy), 8'h01);
      applyStimulus(1'b1, 4'b0000, 4'b0000);
      checkOutput("single_idle_busy", 8'(busy), 8'h00);
      checkOutput("single_idle_sel", 8'(sel), 8'h02);

      // All four requesting continuously, with done pulsed in each grant cycle.
      applyStimulus(1'b0, 4'b0000, 4'b0000);
      expSeq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, 4'b1111, mGrant);
         checkOutput($sformatf("rr_seq%0d", i), 8'(grant), 8'(expSeq[i]));
      end

      // done from a non-owner is ignored; dropping the owner's request releases the path.
      applyStimulus(1'b0, 4'b0000, 4'b0000);
      applyStimulus(1'b1, 4'b0010, 4'b0000);
      applyStimulus(1'b1, 4'b0010, 4'b1000);
      checkOutput("foreign_done", 8'(grant), 8'h02);
      applyStimulus(1'b1, 4'b0000, 4'b0000);
      checkOutput("req_drop", 8'(grant), 8'h00);

      // Reset in the middle of a grant, then re-arbitration from the reset pointer.
      applyStimulus(1'b0, 4'b0000, 4'b0000);
      applyStimulus(1'b1, 4'b1000, 4'b0000);
      applyStimulus(1'b1, 4'b1000, 4'b0000);
      applyStimulus(1'b0, 4'b1000, 4'b0000);
      checkOutput("midreset_grant", 8'(grant), 8'h00);
      checkOutput("midreset_sel", 8'(sel), 8'h00);
      checkOutput("midreset_busy", 8'(busy), 8'h00);
      checkOutput("midreset_timeout", 8'(timeout), 8'h00);
      applyStimulus(1'b1, 4'b1010, 4'b0000);
      checkOutput("after_reset", 8'(grant), 8'h02);

`ifdef ARB_TIMEOUT_EN
      // With the hold limit built in, requester 0 is cut off after TbMaxHold cycles.
      applyStimulus(1'b0, 4'b0000, 4'b0000);
      for (int i = 0; i < TbMaxHold; i++) begin
         applyStimulus(1'b1, 4'b0011, 4'b0000);
         checkOutput($sformatf("hold%0d", i), 8'(grant), 8'h01);
      end
      applyStimulus(1'b1, 4'b0011, 4'b0000);
      checkOutput("to_pulse", 8'(timeout), 8'h01);
      checkOutput("to_grant", 8'(grant), 8'h00);
      applyStimulus(1'b1, 4'b0011, 4'b0000);
      checkOutput("to_next", 8'(grant), 8'h02);
      checkOutput("to_clear", 8'(timeout), 8'h00);
`else
      // Without the hold limit, a lone requester keeps the path indefinitely.
      applyStimulus(1'b0, 4'b0000, 4'b0000);
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 4'b0001, 4'b0000);
         checkOutput("long_grant", 8'(grant), 8'h01);
         checkOutput("long_timeout", 8'(timeout), 8'h00);
      end
`endif

      // Random traffic: sticky request patterns, sparse done pulses, occasional reset.
      applyStimulus(1'b0, 4'b0000, 4'b0000);
      rr = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            rr = 4'($urandom_range(0, 15));
         end
         dd = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         rn = ($urandom_range(0, 99) != 0);
         applyStimulus(rn, rr, dd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
